// File: rtl/uart_packet_scheduler.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among four 16-bit requesters.
// Each grant becomes a 3-byte packet: header {HDR_TAG,2'b00,ch}, word[15:8], word[7:0].
module uart_packet_scheduler #(
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [3:0]  ChEnable,
  input  logic [63:0] Data,
  output logic [3:0]  Ack,
  output logic        TxStart,
  output logic [7:0]  TxData,
  input  logic        TxBusy,
  output logic        Busy,
  output logic [15:0] PacketCount
);

  typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_HI, SEND_LO, GAP} state_t;

  state_t      state;
  logic [1:0]  last_grant;
  logic [1:0]  ch;
  logic [1:0]  byte_sel;
  logic [15:0] word;

  logic [3:0]  eligible;
  logic        grant_valid;
  logic [1:0]  grant_ch;

  // Scan from the lowest priority offset upward so the nearest channel after last_grant wins.
  always_comb begin
    eligible    = Req & ChEnable;
    grant_valid = 1'b0;
    grant_ch    = last_grant;
    for (int unsigned i = 4; i > 0; i--) begin
      if (eligible[last_grant + 2'(i)]) begin
        grant_valid = 1'b1;
        grant_ch    = last_grant + 2'(i);
      end
    end
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      last_grant  <= 2'd3;
      ch          <= '0;
      byte_sel    <= '0;
      word        <= '0;
      Ack         <= '0;
      TxStart     <= 1'b0;
      TxData      <= '0;
      PacketCount <= '0;
    end else begin
      Ack     <= '0;
      TxStart <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            word       <= Data[{grant_ch, 4'b0000} +: 16];
            ch         <= grant_ch;
            last_grant <= grant_ch;
            Ack        <= 4'b0001 << grant_ch;
            state      <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          if (!TxBusy) begin
            TxStart  <= 1'b1;
            TxData   <= {HDR_TAG, 2'b00, ch};
            byte_sel <= 2'd1;
            state    <= GAP;
          end
        end
        SEND_HI: begin
          if (!TxBusy) begin
            TxStart  <= 1'b1;
            TxData   <= word[15:8];
            byte_sel <= 2'd2;
            state    <= GAP;
          end
        end
        SEND_LO: begin
          if (!TxBusy) begin
            TxStart  <= 1'b1;
            TxData   <= word[7:0];
            byte_sel <= 2'd3;
            state    <= GAP;
          end
        end
        GAP: begin
          case (byte_sel)
            2'd1:    state <= SEND_HI;
            2'd2:    state <= SEND_LO;
            default: begin
              state       <= IDLE;
              PacketCount <= PacketCount + 16'd1;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_scheduler.sv
// Directed bench for uart_packet_scheduler: scoreboard of expected Acks and transmitted bytes,
// with a simple transmitter model that holds busy for a programmable number of cycles.
module tb_uart_packet_scheduler;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req;
  logic [3:0]  ChEnable;
  logic [63:0] Data;
  logic [3:0]  Ack;
  logic        TxStart;
  logic [7:0]  TxData;
  logic        TxBusy;
  logic        Busy;
  logic [15:0] PacketCount;

  uart_packet_scheduler #(.HDR_TAG(4'hA)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ChEnable(ChEnable), .Data(Data),
    .Ack(Ack), .TxStart(TxStart), .TxData(TxData), .TxBusy(TxBusy),
    .Busy(Busy), .PacketCount(PacketCount)
  );

  int compared = 0;
  int mismatched = 0;

  logic [3:0]  exp_ack[$];
  logic [7:0]  exp_byte[$];
  logic [15:0] words[4];

  int   busy_len = 0;
  int   busy_cnt = 0;
  logic busy_force = 1'b0;
  logic busy_prev = 1'b0;
  logic hold_req = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Transmitter model: busy rises the cycle after it sees a start pulse.
  always @(posedge Clock) begin
    if (TxStart) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign TxBusy = busy_force | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_packet(input int c);
    exp_ack.push_back(4'b0001 << c);
    exp_byte.push_back(8'hA0 + 8'(c));
    exp_byte.push_back(words[c][15:8]);
    exp_byte.push_back(words[c][7:0]);
  endtask

  task automatic run_until_count(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (PacketCount !== target && n < budget) begin
      @(negedge Clock);
      n++;
      if (!hold_req) Req = Req & ~Ack;
    end
    check({tag, " count"}, 32'(PacketCount), 32'(target));
    check({tag, " busy"}, 32'(Busy), 32'd0);
  endtask

  always @(negedge Clock) begin
    if (Ack !== 4'b0000) begin
      if (exp_ack.size() == 0) check("unexpected ack", 32'(Ack), 32'd0);
      else check("ack", 32'(Ack), 32'(exp_ack.pop_front()));
    end
    if (TxStart === 1'b1) begin
      check("start while busy", 32'(busy_prev), 32'd0);
      if (exp_byte.size() == 0) check("unexpected byte", 32'(TxData), 32'h100);
      else check("byte", 32'(TxData), 32'(exp_byte.pop_front()));
    end
    busy_prev = TxBusy;
  end

  initial begin
    int starts;
    int n;
    words[0] = 16'h1234;
    words[1] = 16'h5678;
    words[2] = 16'h9ABC;
    words[3] = 16'hDEF0;
    Data = {words[3], words[2], words[1], words[0]};
    Reset = 1'b1;
    Req = '0;
    ChEnable = 4'hF;
    repeat (3) @(negedge Clock);
    check("reset ack", 32'(Ack), 32'd0);
    check("reset txstart", 32'(TxStart), 32'd0);
    check("reset txdata", 32'(TxData), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset count", 32'(PacketCount), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // 1: single packet from channel 0, latency check
    Req = 4'b0001;
    push_packet(0);
    @(negedge Clock);
    check("t1 ack latency", 32'(Ack), 32'h1);
    Req = '0;
    @(negedge Clock);
    check("t1 ack one cycle", 32'(Ack), 32'h0);
    check("t1 hdr latency", 32'(TxStart), 32'h1);
    run_until_count(16'd1, 100, "t1");

    // 2: all channels requesting continuously, fresh priority from reset
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    busy_len = 10;
    hold_req = 1'b1;
    for (int i = 0; i < 5; i++) push_packet(i % 4);
    Req = 4'hF;
    run_until_count(16'd5, 1000, "t2");
    Req = '0;
    hold_req = 1'b0;
    check("t2 acks drained", 32'(exp_ack.size()), 32'd0);
    repeat (12) @(negedge Clock);

    // 3: channel 1 requests but is disabled
    ChEnable = 4'b0100;
    Req = 4'b0110;
    push_packet(2);
    run_until_count(16'd6, 300, "t3");
    repeat (10) @(negedge Clock);
    check("t3 busy stays idle", 32'(Busy), 32'd0);
    Req = '0;
    ChEnable = 4'hF;
    repeat (12) @(negedge Clock);

    // 4: transmitter held busy for 50 cycles
    busy_len = 0;
    busy_force = 1'b1;
    Req = 4'b0001;
    push_packet(0);
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      Req = Req & ~Ack;
      if (TxStart) starts++;
    end
    check("t4 no start while busy", 32'(starts), 32'd0);
    busy_force = 1'b0;
    @(negedge Clock);
    check("t4 start after busy falls", 32'(TxStart), 32'h1);
    run_until_count(16'd7, 100, "t4");

    // 5: asynchronous reset right after the HI byte is handed over
    busy_len = 10;
    Req = 4'b0010;
    exp_ack.push_back(4'b0010);
    exp_byte.push_back(8'hA1);
    exp_byte.push_back(words[1][15:8]);
    n = 0;
    while (exp_byte.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
      Req = Req & ~Ack;
    end
    check("t5 hi byte reached", 32'(exp_byte.size()), 32'd0);
    #2 Reset = 1'b1;
    #1;
    check("t5 txstart async", 32'(TxStart), 32'd0);
    check("t5 ack", 32'(Ack), 32'd0);
    check("t5 txdata", 32'(TxData), 32'd0);
    check("t5 busy", 32'(Busy), 32'd0);
    check("t5 count", 32'(PacketCount), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    busy_len = 2;
    Req = 4'b1000;
    push_packet(3);
    run_until_count(16'd1, 300, "t5");

    // 6: packet counter wrap
    @(negedge Clock);
    force dut.PacketCount = 16'hFFFF;
    @(negedge Clock);
    release dut.PacketCount;
    @(negedge Clock);
    check("t6 preset count", 32'(PacketCount), 32'hFFFF);
    Req = 4'b0001;
    push_packet(0);
    run_until_count(16'h0000, 300, "t6");

    repeat (5) @(negedge Clock);
    check("final acks drained", 32'(exp_ack.size()), 32'd0);
    check("final bytes drained", 32'(exp_byte.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_packet_scheduler.md
Name: uart_packet_scheduler

Overview:
- Round-robin scheduler that shares the single byte-wide UART transmitter between four 16-bit data requesters.
- Each granted word is framed as a 3-byte packet: header, data[15:8], data[7:0].
- Sits between the acquisition channels and the async_transmitter, driving its start/data inputs and pacing on its busy output.

Parameters:
HDR_TAG, 4'hA, upper nibble of every header byte (receiver sync marker)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high; clears all state immediately
Req  in  4  per-channel request; held high by requester until its Ack
ChEnable  in  4  per-channel enable; Req of a disabled channel is ignored
Data  in  64  channel i word at Data[16i+15:16i]; stable while Req[i] high
Ack  out  4  one-hot, one-cycle pulse: word of that channel captured
TxStart  out  1  one-cycle start pulse to transmitter
TxData  out  8  byte to transmitter; valid and stable while TxStart high
TxBusy  in  1  transmitter busy; byte may start only when low
Busy  out  1  high whenever state is not IDLE
PacketCount  out  16  completed packets since reset; wraps FFFF->0000

Behaviour:
- Reset values: Ack=0, TxStart=0, TxData=0, Busy=0, PacketCount=0, state=IDLE, LastGrant=3 (so channel 0 has first priority), word buffer=0.
- States: IDLE, SEND_HDR, SEND_HI, SEND_LO, GAP.
- IDLE, Eligible = Req & ChEnable:
  - When Eligible is nonzero, grant the first set bit searching LastGrant+1, LastGrant+2, ... modulo 4.
  - On that edge: latch the 16-bit word and the channel index, set LastGrant to the granted channel, pulse Ack[granted] for the following cycle, go to SEND_HDR.
- SEND_x, where x is HDR, HI or LO:
  - While TxBusy=1, hold.
  - When TxBusy=0, assert TxStart for exactly one cycle with TxData set to the byte for x, then go to GAP.
  - Bytes: header={HDR_TAG,2'b00,ch[1:0]}; HI=word[15:8]; LO=word[7:0].
- GAP: one mandatory cycle so the transmitter's busy flag can rise. Then go to the next SEND state, or to IDLE after LO.
- Packet completion: PacketCount increments on the GAP->IDLE transition.
- Ack and TxStart are registered outputs.
- Latency: Req seen in IDLE at edge k gives Ack high in cycle k+1. With TxBusy=0, the header TxStart is high in cycle k+2.
- Minimum spacing between TxStart pulses is 2 cycles. In practice spacing is set by TxBusy.
- TxData holds its last value between pulses.
- Requests arriving while not IDLE wait. Req is not latched; a requester must keep Req high.
- A requester that keeps Req high after Ack is treated as a new request, subject to round-robin order.
- ChEnable and Req changes during a packet do not affect the packet in flight.
- All four channels requesting continuously are served in order 0,1,2,3,0,... with no starvation.
- Back-to-back packets: IDLE may grant on the cycle after the final GAP.
- Reset mid-packet: state and outputs clear at once. TxStart drops asynchronously. A byte already handed to the transmitter completes on the line. The remaining bytes of that packet are dropped and PacketCount is not incremented.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then Req=0001, ChEnable=1111, Data[15:0]=16'h1234, TxBusy=0 -> Ack=0001 for one cycle. TxStart pulses carry A0, 12, 34. PacketCount=1. Busy returns to 0.
2. Req=1111 held continuously, TxBusy model busy for 10 cycles after each start -> grant order 0,1,2,3,0. Headers A0, A1, A2, A3, A0. No two TxStart pulses while TxBusy=1.
3. Req=0110, ChEnable=0100 -> only channel 2 granted (header A2). Ack[1] never asserts.
4. TxBusy held 1 for 50 cycles after Ack -> TxStart stays 0 until TxBusy falls. Header issued on the first cycle after TxBusy=0.
5. Assert Reset asynchronously between the HI and LO bytes -> all outputs 0 immediately. PacketCount=0. After release with Req=1000, next header is A3.
6. Force PacketCount to FFFF and complete one packet -> PacketCount=0000.
